// File: rtl/uart_tx_engine_pkg.sv
// uart_tx_engine_pkg: state encodings and line levels shared by the UART transmitter and receiver
package uart_tx_engine_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
endpackage

// File: rtl/uart_tx_engine.sv
// uart_tx_engine: baud-tick driven UART framer with a one-entry holding register
// Define UART_TX_PARITY_EN to compile in the parity bit (and the PAR_ODD parameter).
module uart_tx_engine
  import uart_tx_engine_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
`ifdef UART_TX_PARITY_EN
  , parameter bit PAR_ODD = 1'b0
`endif
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_out,
  output logic                 tx_busy,
  output logic                 tx_done
);
  localparam int CNT_W = $clog2(DATA_BITS + 1);
  state_t               state, state_n;
  logic                 hold_full;
  logic [DATA_BITS-1:0] hold_data, shift, shift_n;
  logic [CNT_W-1:0]     bit_cnt, bit_cnt_n;
  logic                 stop_cnt, stop_cnt_n, line_n, stop_last, load;
  assign stop_last = stop_cnt == 1'(STOP_BITS - 1);
  assign load      = baud_tick && hold_full && (state == IDLE || (state == STOP && stop_last));
  assign tx_ready  = !hold_full;
  assign tx_busy   = state != IDLE;
  assign tx_done   = baud_tick && state == STOP && stop_last;
  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) begin
      hold_full <= 1'b0;
      hold_data <= '0;
    end else if (tx_valid && !hold_full) begin
      hold_full <= 1'b1;
      hold_data <= tx_data;
    end else if (load) hold_full <= 1'b0;
`ifdef UART_TX_PARITY_EN
  logic par;
  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) par <= 1'b0;
    else if (load) par <= ^hold_data ^ PAR_ODD;
`endif
  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      tx_out   <= LINE_IDLE;
    end else begin
      state    <= state_n;
      shift    <= shift_n;
      bit_cnt  <= bit_cnt_n;
      stop_cnt <= stop_cnt_n;
      tx_out   <= line_n;
    end
  always_comb begin
    state_n    = state;
    shift_n    = shift;
    bit_cnt_n  = bit_cnt;
    stop_cnt_n = stop_cnt;
    line_n     = tx_out;
    if (baud_tick)
      case (state)
        IDLE: if (hold_full) begin
          state_n = START;
          shift_n = hold_data;
          line_n  = LINE_START;
        end
        START: begin
          state_n   = DATA;
          line_n    = shift[0];
          bit_cnt_n = '0;
        end
        DATA: begin
          shift_n   = shift >> 1;
          bit_cnt_n = bit_cnt + CNT_W'(1);
          line_n    = shift[1];
          if (bit_cnt == CNT_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
            line_n  = par;
`else
            state_n    = STOP;
            line_n     = LINE_IDLE;
            stop_cnt_n = 1'b0;
`endif
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          state_n    = STOP;
          line_n     = LINE_IDLE;
          stop_cnt_n = 1'b0;
        end
`endif
        STOP: if (!stop_last) stop_cnt_n = stop_cnt + 1'b1;
          else if (hold_full) begin
            state_n = START;
            shift_n = hold_data;
            line_n  = LINE_START;
          end else begin
            state_n = IDLE;
            line_n  = LINE_IDLE;
          end
        default: begin
          state_n = IDLE;
          line_n  = LINE_IDLE;
        end
      endcase
  end
endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: directed frame checks on an 8N1 instance, a 7-bit/2-stop instance and a spare 8-bit instance
module tb_uart_tx_engine;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int F8 = 10 + PB;
  localparam int F7 = 10 + PB;
  logic       clk, rst_n, tick;
  logic       vld[3];
  logic [7:0] dat0, dat2;
  logic [6:0] dat1;
  logic       ready[3], line[3], busy[3], done[3];
  int         dcnt[3];
  int         n_chk = 0, n_fail = 0;
  uart_tx_engine u0 (.clk_in(clk), .rst_n(rst_n), .baud_tick(tick), .tx_valid(vld[0]), .tx_data(dat0),
                     .tx_ready(ready[0]), .tx_out(line[0]), .tx_busy(busy[0]), .tx_done(done[0]));
  uart_tx_engine #(.DATA_BITS(7), .STOP_BITS(2)) u1 (.clk_in(clk), .rst_n(rst_n), .baud_tick(tick),
                     .tx_valid(vld[1]), .tx_data(dat1), .tx_ready(ready[1]), .tx_out(line[1]),
                     .tx_busy(busy[1]), .tx_done(done[1]));
`ifdef UART_TX_PARITY_EN
  uart_tx_engine #(.PAR_ODD(1'b1)) u2
`else
  uart_tx_engine u2
`endif
                    (.clk_in(clk), .rst_n(rst_n), .baud_tick(tick), .tx_valid(vld[2]), .tx_data(dat2),
                     .tx_ready(ready[2]), .tx_out(line[2]), .tx_busy(busy[2]), .tx_done(done[2]));
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  initial begin
    tick = 1'b0;
    forever begin
      repeat (15) @(posedge clk);
      #1 tick = 1'b1;
      @(posedge clk);
      #1 tick = 1'b0;
    end
  end
  initial begin
    dcnt = '{0, 0, 0};
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) if (done[i]) dcnt[i]++;
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] fr8(input logic [7:0] d, input logic p);
    return PB != 0 ? {21'b0, 1'b1, p, d, 1'b0} : {22'b0, 1'b1, d, 1'b0};
  endfunction
  function automatic logic [31:0] fr7(input logic [6:0] d, input logic p);
    return PB != 0 ? {21'b0, 2'b11, p, d, 1'b0} : {22'b0, 2'b11, d, 1'b0};
  endfunction
  task automatic wr(input int s, input logic [7:0] d);
    @(posedge clk);
    #1 vld[s] = 1'b1;
    if (s == 0) dat0 = d;
    else if (s == 1) dat1 = d[6:0];
    else dat2 = d;
    @(posedge clk);
    #1 vld[s] = 1'b0;
  endtask
  task automatic wait_start(input string tag, input int s);
    int k = 0;
    @(negedge clk);
    while (line[s] !== 1'b0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_start_seen"}, 32'(k < 60), 1);
  endtask
  // starts at the first negedge of the start bit, samples each bit at its first and last cycle
  task automatic frame(input string tag, input int s, input logic [31:0] bits, input int n);
    logic v0, v15;
    for (int i = 0; i < n; i++) begin
      v0 = line[s];
      repeat (15) @(negedge clk);
      v15 = line[s];
      check($sformatf("%s_bit%0d", tag, i), {30'b0, v0, v15}, {30'b0, bits[i], bits[i]});
      if (i < n - 1) @(negedge clk);
    end
  endtask
  initial begin
    int d, bad;
    rst_n = 1'b0;
    vld = '{1'b0, 1'b0, 1'b0};
    dat0 = '0;
    dat1 = '0;
    dat2 = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++)
      check($sformatf("rst_u%0d", i), {28'b0, line[i], ready[i], busy[i], done[i]}, 32'b1100);
    @(posedge clk);
    #1 rst_n = 1'b1;
    d = dcnt[0];
    wr(0, 8'hA5);
    wait_start("t1", 0);
    frame("t1", 0, fr8(8'hA5, 1'b0), F8);
    #1 check("t1_done_once", 32'(dcnt[0] - d), 1);
    @(negedge clk);
    check("t1_idle", {30'b0, busy[0], line[0]}, 32'b01);
    wr(0, 8'h3C);
    wait_start("t2", 0);
    fork
      frame("t2", 0, (fr8(8'hC3, 1'b0) << F8) | fr8(8'h3C, 1'b0), 2 * F8);
      begin
        repeat (20) @(negedge clk);
        check("t2_ready_pre", 32'(ready[0]), 1);
        @(posedge clk);
        #1 vld[0] = 1'b1;
        dat0 = 8'hC3;
        @(posedge clk);
        #1 vld[0] = 1'b0;
        bad = 0;
        for (int i = 22; i < 16 * F8; i++) begin
          @(negedge clk);
          if (ready[0] !== 1'b0) bad++;
        end
        check("t2_ready_held", 32'(bad), 0);
        @(negedge clk);
        check("t2_ready_freed", 32'(ready[0]), 1);
      end
    join
    @(negedge clk);
    check("t2_idle", {30'b0, busy[0], line[0]}, 32'b01);
    d = dcnt[1];
    wr(1, 8'h55);
    wait_start("t4", 1);
    frame("t4", 1, fr7(7'h55, 1'b0), F7);
    #1 check("t4_busy_last", {30'b0, busy[1], done[1]}, 32'b11);
    check("t4_done_once", 32'(dcnt[1] - d), 1);
    @(negedge clk);
    check("t4_busy_fall", {30'b0, busy[1], line[1]}, 32'b01);
`ifdef UART_TX_PARITY_EN
    wr(0, 8'h07);
    wait_start("t3e", 0);
    frame("t3e", 0, 32'b111_0000_0111_0, 11);
    wr(2, 8'h07);
    wait_start("t3o", 2);
    frame("t3o", 2, 32'b101_0000_0111_0, 11);
`endif
    do @(negedge clk); while (!tick);
    @(posedge clk);
    #1 vld[0] = 1'b1;
    dat0 = 8'h66;
    @(posedge clk);
    #1 dat0 = 8'h99;
    @(negedge clk);
    check("t6_ready_low_a", 32'(ready[0]), 0);
    @(posedge clk);
    #1 dat0 = 8'h0F;
    @(negedge clk);
    check("t6_ready_low_b", 32'(ready[0]), 0);
    @(posedge clk);
    #1 vld[0] = 1'b0;
    wait_start("t6", 0);
    frame("t6", 0, fr8(8'h66, 1'b0), F8);
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (line[0] !== 1'b1) bad++;
    end
    check("t6_no_extra_frame", 32'(bad), 0);
    wr(0, 8'hA5);
    wait_start("t5", 0);
    wr(0, 8'hFF);
    repeat (67) @(negedge clk);
    check("t5_pre_reset", {30'b0, line[0], ready[0]}, 32'b00);
    #2 rst_n = 1'b0;
    #1 check("t5_async_reset", {29'b0, line[0], ready[0], busy[0]}, 32'b110);
    @(posedge clk);
    #2 rst_n = 1'b1;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (line[0] !== 1'b1) bad++;
    end
    check("t5_hold_cleared", 32'(bad), 0);
    wr(0, 8'h5A);
    wait_start("t5b", 0);
    frame("t5b", 0, fr8(8'h5A, 1'b0), F8);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
